mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_AW, default 17, meaning RAM byte-address width (128 KB).
REQ-002 Parameter FIFO_DEPTH, default 8, meaning entries per RX and TX FIFO (power of two, >= 4).
REQ-003 clk_in  input  1  single clock, all state on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 mem_a  input  32  CPU address bus; bits [17:0] used.
REQ-006 mem_dout  input  8  CPU write data.
REQ-007 mem_wr  input  1  1 = write, 0 = read.
REQ-008 mem_din  output  8  read data to CPU, registered.
REQ-009 io_buffer_full  output  1  TX FIFO near-full indication to CPU.
REQ-010 rx_valid / rx_data  input  1 / 8  UART-side byte offer into RX FIFO.
REQ-011 rx_ready  output  1  RX FIFO can accept a byte.
REQ-012 tx_valid / tx_data  output  1 / 8  head of TX FIFO offered to UART.
REQ-013 tx_ready  input  1  UART accepts tx_data this cycle.
REQ-014 program_stop  output  1  sticky, program signalled termination.
REQ-015 tx_overflow  output  1  sticky, a TX byte was dropped.

Function
REQ-016 IO region SHALL be mem_a[17:16]==2'b11; all other addresses SHALL map to RAM at mem_a[RAM_AW-1:0].
REQ-017 RAM write: mem_wr=1 in RAM region SHALL store mem_dout at the edge; no wait state.
REQ-018 RAM read: mem_wr=0 in RAM region SHALL present the byte on mem_din exactly one cycle later; read after write to same address on the next cycle SHALL return new data.
REQ-019 Read 0x30000: if RX FIFO non-empty, pop and present head on mem_din next cycle; if empty, mem_din=0x00, no pop.
REQ-020 Write 0x30000: nonzero mem_dout SHALL push to TX FIFO; 0x00 SHALL be ignored; push while full (and no same-cycle pop) SHALL drop the byte and set tx_overflow.
REQ-021 Read 0x30004..0x30007: byte mem_a[1:0] of cycle-count snapshot, little-endian; read of 0x30004 SHALL load snapshot from live counter and return its byte 0 in the same response.
REQ-022 Cycle counter: 32-bit, +1 every cycle from reset, wraps 0xFFFFFFFF->0, SHALL freeze once program_stop is set.
REQ-023 Write 0x30004 SHALL set program_stop; further writes SHALL not clear it.
REQ-024 Other IO addresses: reads return 0x00 next cycle, writes ignored.
REQ-025 mem_din SHALL hold its last value in cycles following a write or idle.
REQ-026 io_buffer_full SHALL be 1 when TX count >= FIFO_DEPTH-1 (one-slot margin for CPU issue latency), combinational from count.
REQ-027 tx_valid = TX non-empty; tx_data = TX head; pop when tx_valid && tx_ready.
REQ-028 rx_ready = RX not full; push when rx_valid && rx_ready.
REQ-029 Simultaneous push and pop on either FIFO SHALL leave count unchanged, including on a full TX FIFO (write accepted, no overflow) and an empty RX FIFO (bypass not allowed: CPU read returns 0x00, byte is stored).
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-031 On rst_in high, immediately: mem_din=0x00, FIFOs empty (tx_valid=0, rx_ready=1), io_buffer_full=0, counter=0, snapshot=0, program_stop=0, tx_overflow=0.
REQ-032 RAM contents SHALL be unaffected by reset.
REQ-033 Reset mid-transfer SHALL abandon any pending read response; first post-reset response follows first post-reset request.

Verification
REQ-034 Write 0xA5 to 0x00123, read 0x00123 next cycle -> mem_din=0xA5 one cycle after read.
REQ-035 Write 0x41,0x00,0x42 to 0x30000 with tx_ready=0 -> TX holds 2 bytes 0x41,0x42; tx_ready=1 -> delivered in order.
REQ-036 Fill TX with FIFO_DEPTH-1 bytes -> io_buffer_full=1; one more write -> full, tx_overflow=0; another -> dropped, tx_overflow=1.
REQ-037 Read 0x30000 with RX empty -> 0x00; push 0x37 via rx_valid, read -> 0x37, RX empty after.
REQ-038 Reset, wait 0x100 cycles, read 0x30004..0x30007 -> bytes form a value equal to cycle of 0x30004 read, coherent across all four.
REQ-039 Write 0x30004 -> program_stop=1, counter frozen; assert rst_in mid-run -> all outputs at REQ-031 values same cycle.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - CPU byte bus, UART byte streams and status flags of mem_io_responder
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        program_stop;
    logic        tx_overflow;

    modport master (
        output mem_a, mem_dout, mem_wr, rx_valid, rx_data, tx_ready,
        input  mem_din, io_buffer_full, rx_ready, tx_valid, tx_data, program_stop, tx_overflow
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr, rx_valid, rx_data, tx_ready,
        output mem_din, io_buffer_full, rx_ready, tx_valid, tx_data, program_stop, tx_overflow
    );
endinterface

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte RAM plus UART RX/TX FIFOs and cycle counter behind a CPU bus
module mem_io_responder #(
    parameter int RAM_AW     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input logic               clk_in,
    input logic               rst_in,
    mem_io_responder_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C    = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] NEAR_FULL  = (PW+1)'(FIFO_DEPTH - 1);

    logic [7:0] ram    [2**RAM_AW];
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];

    logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [PW:0]   tx_count, rx_count;
    logic [31:0]   cycle_count, snapshot;
    logic [7:0]    din_q;
    logic          stop_q, ovf_q;

    logic              io_hit, sel_data, sel_cyc, sel_stop;
    logic [RAM_AW-1:0] ram_addr;
    logic              tx_full, rx_full, tx_pop, tx_wr_req, tx_push, rx_push, rx_pop;
    logic [13:0]       unused_addr;

    assign unused_addr = bus.mem_a[31:18];
    assign io_hit   = bus.mem_a[17:16] == 2'b11;
    assign ram_addr = bus.mem_a[RAM_AW-1:0];
    assign sel_data = io_hit && bus.mem_a[15:0] == 16'h0000;
    assign sel_cyc  = io_hit && bus.mem_a[15:2] == 14'h0001;
    assign sel_stop = io_hit && bus.mem_a[15:0] == 16'h0004;

    assign tx_full   = tx_count == DEPTH_C;
    assign rx_full   = rx_count == DEPTH_C;
    assign tx_pop    = (tx_count != '0) && bus.tx_ready;
    assign tx_wr_req = bus.mem_wr && sel_data && (bus.mem_dout != 8'h00);
    // A full TX FIFO still takes the write when the UART drains a byte the same cycle.
    assign tx_push   = tx_wr_req && (!tx_full || tx_pop);
    assign rx_push   = bus.rx_valid && !rx_full;
    assign rx_pop    = !bus.mem_wr && sel_data && (rx_count != '0);

    assign bus.mem_din        = din_q;
    assign bus.io_buffer_full = tx_count >= NEAR_FULL;
    assign bus.rx_ready       = !rx_full;
    assign bus.tx_valid       = tx_count != '0;
    assign bus.tx_data        = tx_mem[tx_rd];
    assign bus.program_stop   = stop_q;
    assign bus.tx_overflow    = ovf_q;

    always_ff @(posedge clk_in) begin
        if (bus.mem_wr && !io_hit) ram[ram_addr] <= bus.mem_dout;
        if (tx_push) tx_mem[tx_wr] <= bus.mem_dout;
        if (rx_push) rx_mem[rx_wr] <= bus.rx_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wr       <= '0;
            tx_rd       <= '0;
            rx_wr       <= '0;
            rx_rd       <= '0;
            tx_count    <= '0;
            rx_count    <= '0;
            cycle_count <= '0;
            snapshot    <= '0;
            din_q       <= 8'h00;
            stop_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (!stop_q) cycle_count <= cycle_count + 32'd1;
            if (bus.mem_wr && sel_stop) stop_q <= 1'b1;
            if (tx_wr_req && !tx_push) ovf_q <= 1'b1;

            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase

            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase

            // Byte 0 of the cycle window reads live and latches the snapshot so bytes 1..3 stay coherent.
            if (!bus.mem_wr) begin
                if (!io_hit) begin
                    din_q <= ram[ram_addr];
                end else if (sel_data) begin
                    din_q <= rx_pop ? rx_mem[rx_rd] : 8'h00;
                end else if (sel_cyc) begin
                    case (bus.mem_a[1:0])
                        2'd0: begin
                            din_q    <= cycle_count[7:0];
                            snapshot <= cycle_count;
                        end
                        2'd1:    din_q <= snapshot[15:8];
                        2'd2:    din_q <= snapshot[23:16];
                        default: din_q <= snapshot[31:24];
                    endcase
                end else begin
                    din_q <= 8'h00;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - scoreboard bench for mem_io_responder
module tb_mem_io_responder;
    localparam logic [31:0] PARK = 32'h0003_FFF0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_req = 1'b0;
    logic chk_d;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [31:0] stop_val;

    exp_t       mem_q[$];
    logic [7:0] tx_q[$];

    mem_io_responder_if bus();

    mem_io_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) chk_d <= 1'b0;
        else     chk_d <= chk_req && !bus.mem_wr;
    end

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] t;
        if (chk_d) begin
            if (mem_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got 0x%0h want none", bus.mem_din);
            end else begin
                e = mem_q.pop_front();
                check(e.name, {24'h0, bus.mem_din}, {24'h0, e.val});
            end
        end
        if (bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got 0x%0h want none", bus.tx_data);
            end else begin
                t = tx_q.pop_front();
                check("tx_data", {24'h0, bus.tx_data}, {24'h0, t});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cpu_rd(input logic [31:0] a, input logic [7:0] e, input string nm);
        bus.mem_a  = a;
        bus.mem_wr = 1'b0;
        chk_req    = 1'b1;
        mem_q.push_back('{nm, e});
        step();
        chk_req    = 1'b0;
        bus.mem_a  = PARK;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_dout = d;
        bus.mem_wr   = 1'b1;
        step();
        bus.mem_wr   = 1'b0;
        bus.mem_a    = PARK;
    endtask

    task automatic drain_tx(input int bound);
        for (int i = 0; i < bound && tx_q.size() != 0; i++) step();
        check("tx_drain_left", tx_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_din"},  {24'h0, bus.mem_din}, 32'h0);
        check({tag, "_tx_valid"}, bus.tx_valid, 0);
        check({tag, "_rx_ready"}, bus.rx_ready, 1);
        check({tag, "_io_full"},  bus.io_buffer_full, 0);
        check({tag, "_stop"},     bus.program_stop, 0);
        check({tag, "_ovf"},      bus.tx_overflow, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_a    = PARK;
        bus.mem_dout = 8'h00;
        bus.mem_wr   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc = 0;

        // cycle counter snapshot: 0x100 then 0x1FF (byte 1 must come from snapshot, not live 0x200)
        repeat (256) step();
        cpu_rd(32'h30004, 8'h00, "cyc100_b0");
        cpu_rd(32'h30005, 8'h01, "cyc100_b1");
        cpu_rd(32'h30006, 8'h00, "cyc100_b2");
        cpu_rd(32'h30007, 8'h00, "cyc100_b3");
        repeat (251) step();
        cpu_rd(32'h30004, 8'hFF, "cyc1ff_b0");
        cpu_rd(32'h30005, 8'h01, "cyc1ff_b1");
        cpu_rd(32'h30006, 8'h00, "cyc1ff_b2");
        cpu_rd(32'h30007, 8'h00, "cyc1ff_b3");

        // RAM write/read, alias through RAM_AW, hold after write
        cpu_wr(32'h00123, 8'hA5);
        cpu_rd(32'h00123, 8'hA5, "ram_raw");
        cpu_wr(32'h00200, 8'h3C);
        check("din_hold_after_wr", {24'h0, bus.mem_din}, 32'hA5);
        cpu_rd(32'h00200, 8'h3C, "ram_200");
        cpu_rd(32'h20123, 8'hA5, "ram_alias");

        // TX ordering and zero filtering
        cpu_wr(32'h30000, 8'h41);
        cpu_wr(32'h30000, 8'h00);
        cpu_wr(32'h30000, 8'h42);
        check("tx_valid_held", bus.tx_valid, 1);
        tx_q.push_back(8'h41);
        tx_q.push_back(8'h42);
        bus.tx_ready = 1'b1;
        drain_tx(20);
        bus.tx_ready = 1'b0;
        check("tx_empty", bus.tx_valid, 0);

        // TX near-full, full, overflow, full with same-cycle pop
        for (int i = 1; i <= 6; i++) cpu_wr(32'h30000, 8'(i));
        check("io_full_at6", bus.io_buffer_full, 0);
        cpu_wr(32'h30000, 8'h07);
        check("io_full_at7", bus.io_buffer_full, 1);
        cpu_wr(32'h30000, 8'h08);
        check("ovf_at_full", bus.tx_overflow, 0);
        cpu_wr(32'h30000, 8'h09);
        check("ovf_dropped", bus.tx_overflow, 1);
        for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
        tx_q.push_back(8'h0A);
        bus.tx_ready = 1'b1;
        cpu_wr(32'h30000, 8'h0A);
        check("io_full_pushpop", bus.io_buffer_full, 1);
        drain_tx(30);
        bus.tx_ready = 1'b0;
        check("ovf_sticky", bus.tx_overflow, 1);

        // RX: empty read, single byte, push+pop on empty, full
        cpu_rd(32'h30000, 8'h00, "rx_empty");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h37;
        step();
        bus.rx_valid = 1'b0;
        cpu_rd(32'h30000, 8'h37, "rx_37");
        cpu_rd(32'h30000, 8'h00, "rx_empty_after");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5A;
        cpu_rd(32'h30000, 8'h00, "rx_no_bypass");
        bus.rx_valid = 1'b0;
        cpu_rd(32'h30000, 8'h5A, "rx_5a_stored");
        for (int i = 0; i < 8; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'(8'h10 + i);
            step();
        end
        bus.rx_valid = 1'b0;
        check("rx_full_ready", bus.rx_ready, 0);
        for (int i = 0; i < 8; i++) cpu_rd(32'h30000, 8'(8'h10 + i), "rx_full_data");
        check("rx_ready_after", bus.rx_ready, 1);

        // other IO addresses
        cpu_rd(32'h30008, 8'h00, "io_other_rd");
        cpu_wr(32'h30001, 8'h55);
        check("io_other_wr", bus.tx_valid, 0);

        // program stop freezes the counter
        stop_val = cyc + 1;
        cpu_wr(32'h30004, 8'h01);
        check("stop_set", bus.program_stop, 1);
        repeat (5) step();
        cpu_wr(32'h30004, 8'h00);
        check("stop_sticky", bus.program_stop, 1);
        cpu_rd(32'h30004, stop_val[7:0], "frozen_b0");
        cpu_rd(32'h30005, stop_val[15:8], "frozen_b1");

        // asynchronous reset mid-run with a read outstanding
        cpu_wr(32'h30000, 8'h66);
        cpu_rd(32'h00123, 8'hA5, "pre_reset_rd");
        bus.mem_a = 32'h00200;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun");
        step();
        step();
        bus.mem_a = PARK;
        rst = 1'b0;
        cyc = 0;
        check("post_rst_din", {24'h0, bus.mem_din}, 32'h0);
        cpu_rd(32'h00123, 8'hA5, "ram_survives_rst");
        cpu_rd(32'h30004, 8'h01, "cnt_restart_b0");
        cpu_rd(32'h30005, 8'h00, "cnt_restart_b1");
        step();
        check("mem_q_empty", mem_q.size(), 0);
        check("tx_q_empty", tx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
